// File: rtl/bit_reverse_stream.sv
// Ping-pong frame buffer that re-emits each N-coefficient frame in bit-reversed
// or natural order, chosen per frame by rev_en sampled on the frame's first word.
module bit_reverse_stream #(
    parameter int DATA_W = 8,
    parameter int LOG_N  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              rev_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              frame_err
);

    localparam int N = 1 << LOG_N;
    localparam logic [LOG_N-1:0] CNT_LAST = '1;

    logic [DATA_W-1:0] mem_q [2][N];

    logic [LOG_N-1:0] inCnt_q,  inCnt_d;
    logic [LOG_N-1:0] outCnt_q, outCnt_d;
    logic             wrBank_q, wrBank_d;
    logic             rdBank_q, rdBank_d;
    logic [1:0]       full_q,   full_d;
    logic [1:0]       revSel_q, revSel_d;
    logic             frameErr_q, frameErr_d;

    logic             inFire;
    logic             outFire;
    logic             inFrameEnd;
    logic             outFrameEnd;
    logic [LOG_N-1:0] rdAddr;

    function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] a);
        logic [LOG_N-1:0] r;
        for (int i = 0; i < LOG_N; i++) begin
            r[i] = a[LOG_N-1-i];
        end
        return r;
    endfunction

    assign in_ready    = !full_q[wrBank_q];
    assign out_valid   = full_q[rdBank_q];
    assign inFire      = in_valid & in_ready;
    assign outFire     = out_valid & out_ready;
    assign inFrameEnd  = (inCnt_q == CNT_LAST);
    assign outFrameEnd = (outCnt_q == CNT_LAST);

    // Read address is combinational so the first word appears the cycle after the bank fills.
    assign rdAddr    = revSel_q[rdBank_q] ? bitrev(outCnt_q) : outCnt_q;
    assign out_data  = mem_q[rdBank_q][rdAddr];
    assign out_last  = out_valid & outFrameEnd;
    assign frame_err = frameErr_q;

    always_comb begin
        inCnt_d    = inCnt_q;
        outCnt_d   = outCnt_q;
        wrBank_d   = wrBank_q;
        rdBank_d   = rdBank_q;
        full_d     = full_q;
        revSel_d   = revSel_q;
        frameErr_d = frameErr_q;

        if (inFire) begin
            inCnt_d = inCnt_q + 1'b1;
            if (inCnt_q == '0) begin
                revSel_d[wrBank_q] = rev_en;
            end
            if (in_last != inFrameEnd) begin
                frameErr_d = 1'b1;
            end
            if (inFrameEnd) begin
                full_d[wrBank_q] = 1'b1;
                wrBank_d         = ~wrBank_q;
            end
        end

        // Fill and drain always target different banks, so these never collide.
        if (outFire) begin
            outCnt_d = outCnt_q + 1'b1;
            if (outFrameEnd) begin
                full_d[rdBank_q] = 1'b0;
                rdBank_d         = ~rdBank_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inCnt_q    <= '0;
            outCnt_q   <= '0;
            wrBank_q   <= 1'b0;
            rdBank_q   <= 1'b0;
            full_q     <= 2'b00;
            revSel_q   <= 2'b00;
            frameErr_q <= 1'b0;
        end else begin
            inCnt_q    <= inCnt_d;
            outCnt_q   <= outCnt_d;
            wrBank_q   <= wrBank_d;
            rdBank_q   <= rdBank_d;
            full_q     <= full_d;
            revSel_q   <= revSel_d;
            frameErr_q <= frameErr_d;
        end
    end

    // Bank contents are left uncleared by reset; the full flags make stale words invisible.
    always_ff @(posedge clk) begin
        if (inFire) begin
            mem_q[wrBank_q][inCnt_q] <= in_data;
        end
    end

endmodule
